// File: rtl/warp_controller_pkg.sv
// Shared state encoding and lane/word geometry helpers
// for the warp controller and its lane unpacker.
package warp_controller_pkg;

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_RECV = 4'b0010,
    ST_EXEC = 4'b0100,
    ST_SEND = 4'b1000
  } state_t;

  function automatic int lanes_of(input int bus_w, input int elem_w);
    return bus_w / elem_w;
  endfunction

  function automatic int words_of(input int threads, input int lanes);
    return threads / lanes;
  endfunction

endpackage

// File: rtl/warp_lane_unpack.sv
// Scatters one host word across LANES thread operand slots
// and latches their valid bits until cleared.
module warp_lane_unpack
  import warp_controller_pkg::*;
#(
  parameter int BUS_W   = 32,
  parameter int ELEM_W  = 16,
  parameter int THREADS = 512,
  parameter int CW      = 9
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      wr_en,
  input  logic [CW-1:0]             wr_idx,
  input  logic [BUS_W-1:0]          word,
  output logic [THREADS*ELEM_W-1:0] data,
  output logic [THREADS-1:0]        valid
);

  localparam int LANES = lanes_of(BUS_W, ELEM_W);

  for (genvar t = 0; t < THREADS; t++) begin : g_thr
    localparam int WI = t / LANES;
    localparam int LN = t % LANES;

    logic hit;
    assign hit = wr_en && (wr_idx == CW'(WI));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        data[t*ELEM_W +: ELEM_W] <= '0;
        valid[t]                 <= 1'b0;
      end else if (clear) begin
        valid[t] <= 1'b0;
      end else if (hit) begin
        data[t*ELEM_W +: ELEM_W] <= word[LN*ELEM_W +: ELEM_W];
        valid[t]                 <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/warp_controller.sv
// Batches host words into a thread array, waits for all kernels,
// then streams the results back to the host.
module warp_controller
  import warp_controller_pkg::*;
#(
  parameter int BUS_W   = 32,
  parameter int ELEM_W  = 16,
  parameter int THREADS = 512
) (
  input  logic                      bus_clk,
  input  logic                      rst,
  input  logic                      enable,
  output logic                      recv_rden,
  input  logic                      recv_empty,
  input  logic [BUS_W-1:0]          recv_data,
  input  logic                      recv_valid,
  output logic                      send_wren,
  output logic [BUS_W-1:0]          send_data,
  input  logic                      send_almost_full,
  output logic [THREADS*ELEM_W-1:0] kern_in_data,
  output logic [THREADS-1:0]        kern_in_valid,
  input  logic [THREADS*ELEM_W-1:0] kern_out_data,
  input  logic [THREADS-1:0]        kern_out_valid,
  output logic [3:0]                state,
  output logic [15:0]               batch_count
);

  localparam int LANES = lanes_of(BUS_W, ELEM_W);
  localparam int WORDS = words_of(THREADS, LANES);
  localparam int CW    = $clog2(WORDS + 1);

  localparam logic [CW-1:0] FULL = CW'(WORDS);
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  state_t state_q, state_d;

  logic [CW-1:0] req_cnt, wr_cnt, rd_cnt;
  logic          rx_acc, tx_last, clear;

  assign recv_rden = (state_q == ST_RECV) && enable
                  && !recv_empty && (req_cnt < FULL);
  assign rx_acc    = (state_q == ST_RECV) && enable
                  && recv_valid && (wr_cnt < FULL);
  assign send_wren = (state_q == ST_SEND) && enable
                  && !send_almost_full;
  assign tx_last   = send_wren && (rd_cnt == LAST);
  assign clear     = (state_d == ST_IDLE);
  assign state     = state_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (enable) state_d = ST_RECV;
      ST_RECV: begin
        if (!enable)
          state_d = ST_IDLE;
        else if (rx_acc && wr_cnt == LAST)
          state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (!enable)
          state_d = ST_IDLE;
        else if (&kern_out_valid)
          state_d = ST_SEND;
      end
      ST_SEND: begin
        if (!enable || tx_last)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge bus_clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Every way back to IDLE discards partial progress.
  always_ff @(posedge bus_clk or posedge rst) begin
    if (rst) begin
      req_cnt <= '0;
      wr_cnt  <= '0;
      rd_cnt  <= '0;
    end else if (clear) begin
      req_cnt <= '0;
      wr_cnt  <= '0;
      rd_cnt  <= '0;
    end else begin
      if (recv_rden) req_cnt <= req_cnt + 1'b1;
      if (rx_acc)    wr_cnt  <= wr_cnt + 1'b1;
      if (send_wren) rd_cnt  <= rd_cnt + 1'b1;
    end
  end

  always_ff @(posedge bus_clk or posedge rst) begin
    if (rst)
      batch_count <= '0;
    else if (state_q == ST_SEND && tx_last)
      batch_count <= batch_count + 16'd1;
  end

  always_comb begin
    send_data = '0;
    for (int w = 0; w < WORDS; w++)
      if (rd_cnt == CW'(w))
        send_data = kern_out_data[w*BUS_W +: BUS_W];
  end

  warp_lane_unpack #(
    .BUS_W   (BUS_W),
    .ELEM_W  (ELEM_W),
    .THREADS (THREADS),
    .CW      (CW)
  ) u_unpack (
    .clk    (bus_clk),
    .rst    (rst),
    .clear  (clear),
    .wr_en  (rx_acc),
    .wr_idx (wr_cnt),
    .word   (recv_data),
    .data   (kern_in_data),
    .valid  (kern_in_valid)
  );

endmodule

// File: tb/tb_warp_controller.sv
// Bench for warp_controller: FIFO and kernel models around the DUT,
// expected results computed per thread as operand+1.
module tb_warp_controller;

  localparam int BUS_W   = 32;
  localparam int ELEM_W  = 16;
  localparam int THREADS = 8;
  localparam int LANES   = BUS_W / ELEM_W;
  localparam int WORDS   = THREADS / LANES;

  logic                      bus_clk = 1'b0;
  logic                      rst = 1'b1;
  logic                      enable = 1'b0;
  logic                      recv_rden;
  logic                      recv_empty;
  logic [BUS_W-1:0]          recv_data = '0;
  logic                      recv_valid = 1'b0;
  logic                      send_wren;
  logic [BUS_W-1:0]          send_data;
  logic                      send_almost_full = 1'b0;
  logic [THREADS*ELEM_W-1:0] kern_in_data;
  logic [THREADS-1:0]        kern_in_valid;
  logic [THREADS*ELEM_W-1:0] kern_out_data = '0;
  logic [THREADS-1:0]        kern_out_valid = '0;
  logic [3:0]                state;
  logic [15:0]               batch_count;

  int n_cmp = 0;
  int n_bad = 0;
  int bc_exp = 0;

  logic [BUS_W-1:0] in_mem [256];
  int in_pushed = 0;
  int in_popped = 0;
  logic [BUS_W-1:0] sent_mem [256];
  int sent_cnt = 0;
  int rden_cnt = 0;
  int rden_empty_cnt = 0;
  int allv_cnt = 0;
  bit force_empty = 0;
  bit slow_kern = 0;
  bit kern_hold = 0;

  warp_controller #(
    .BUS_W(BUS_W), .ELEM_W(ELEM_W), .THREADS(THREADS)
  ) dut (
    .bus_clk          (bus_clk),
    .rst              (rst),
    .enable           (enable),
    .recv_rden        (recv_rden),
    .recv_empty       (recv_empty),
    .recv_data        (recv_data),
    .recv_valid       (recv_valid),
    .send_wren        (send_wren),
    .send_data        (send_data),
    .send_almost_full (send_almost_full),
    .kern_in_data     (kern_in_data),
    .kern_in_valid    (kern_in_valid),
    .kern_out_data    (kern_out_data),
    .kern_out_valid   (kern_out_valid),
    .state            (state),
    .batch_count      (batch_count)
  );

  always #5 bus_clk = ~bus_clk;

  assign recv_empty = force_empty || (in_pushed == in_popped);

  // Inbound FIFO, outbound capture and kernel array models.
  always @(posedge bus_clk) begin
    if (recv_rden) begin
      rden_cnt++;
      if (recv_empty) rden_empty_cnt++;
      if (in_pushed != in_popped) begin
        recv_data <= in_mem[in_popped % 256];
        in_popped++;
      end
      recv_valid <= 1'b1;
    end else begin
      recv_valid <= 1'b0;
    end
    if (send_wren) begin
      sent_mem[sent_cnt % 256] = send_data;
      sent_cnt++;
    end
    allv_cnt <= (&kern_in_valid) ? allv_cnt + 1 : 0;
    for (int t = 0; t < THREADS; t++) begin
      kern_out_data[t*ELEM_W +: ELEM_W] <=
        kern_in_data[t*ELEM_W +: ELEM_W] + 16'd1;
      kern_out_valid[t] <= kern_in_valid[t] && !kern_hold
        && (t == THREADS-1 || !slow_kern || allv_cnt >= 3);
    end
  end

  function automatic logic [BUS_W-1:0] exp_word(input logic [BUS_W-1:0] w);
    logic [BUS_W-1:0] r;
    r = '0;
    for (int k = 0; k < LANES; k++)
      r[k*ELEM_W +: ELEM_W] = w[k*ELEM_W +: ELEM_W] + 16'd1;
    return r;
  endfunction

  task automatic push(input logic [BUS_W-1:0] w);
    in_mem[in_pushed % 256] = w;
    in_pushed++;
  endtask

  task automatic wait_sent(input int base, input int n, input int budget,
                           output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge bus_clk);
      if (sent_cnt - base >= n) begin
        ok = 1;
        return;
      end
    end
  endtask

  task automatic wait_state(input logic [3:0] s, input int budget,
                            output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge bus_clk);
      if (state === s) begin
        ok = 1;
        return;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge bus_clk);
    n_cmp++;
    if (state !== 4'b0001) begin
      n_bad++; $display("FAIL reset_state got %h want 1", state);
    end
    n_cmp++;
    if (batch_count !== 16'd0 || kern_in_valid !== '0
        || kern_in_data !== '0) begin
      n_bad++;
      $display("FAIL reset_regs bc=%h kv=%h kd=%h want 0", batch_count,
               kern_in_valid, kern_in_data);
    end
    n_cmp++;
    if (recv_rden !== 1'b0 || send_wren !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_strobes rden=%b wren=%b want 0", recv_rden, send_wren);
    end
    rst = 1'b0;
    @(negedge bus_clk);
    enable = 1'b1;
  endtask

  task automatic test_basic;
    logic [BUS_W-1:0] w [WORDS];
    logic [BUS_W-1:0] req [WORDS];
    int base;
    bit ok;
    w = '{32'h00020001, 32'h00040003, 32'h00060005, 32'h00080007};
    req = '{32'h00030002, 32'h00050004, 32'h00070006, 32'h00090008};
    base = sent_cnt;
    for (int i = 0; i < WORDS; i++) push(w[i]);
    wait_sent(base, WORDS, 200, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++; $display("FAIL basic_timeout got %0d words want 4", sent_cnt - base);
      return;
    end
    bc_exp++;
    n_cmp++;
    if (state !== 4'b0001) begin
      n_bad++; $display("FAIL basic_idle got %h want 1", state);
    end
    for (int i = 0; i < WORDS; i++) begin
      n_cmp++;
      if (sent_mem[(base+i) % 256] !== req[i]) begin
        n_bad++;
        $display("FAIL basic_word%0d got %h want %h", i,
                 sent_mem[(base+i) % 256], req[i]);
      end
    end
    n_cmp++;
    if (batch_count !== 16'(bc_exp)) begin
      n_bad++; $display("FAIL basic_bc got %0d want %0d", batch_count, bc_exp);
    end
  endtask

  task automatic test_empty_stall;
    logic [BUS_W-1:0] w [WORDS];
    logic [THREADS*ELEM_W-1:0] kexp;
    int base, rbase, vbase;
    bit ok;
    for (int i = 0; i < WORDS; i++) w[i] = $urandom;
    base = sent_cnt;
    rbase = rden_cnt;
    vbase = rden_empty_cnt;
    push(w[0]);
    push(w[1]);
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge bus_clk);
      if (rden_cnt - rbase == 2) ok = 1;
    end
    n_cmp++;
    if (!ok) begin
      n_bad++; $display("FAIL stall_first_reads got %0d want 2", rden_cnt - rbase);
    end
    force_empty = 1;
    push(w[2]);
    push(w[3]);
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++;
      if (recv_rden !== 1'b0) begin
        n_bad++; $display("FAIL stall_rden cycle %0d got %b want 0", i, recv_rden);
      end
      @(negedge bus_clk);
    end
    force_empty = 0;
    wait_state(4'b0100, 50, ok);
    for (int t = 0; t < THREADS; t++)
      kexp[t*ELEM_W +: ELEM_W] = w[t/LANES][(t%LANES)*ELEM_W +: ELEM_W];
    n_cmp++;
    if (!ok || kern_in_data !== kexp || kern_in_valid !== '1) begin
      n_bad++;
      $display("FAIL stall_place got %h/%h want %h/ff", kern_in_data,
               kern_in_valid, kexp);
    end
    wait_sent(base, WORDS, 100, ok);
    bc_exp++;
    n_cmp++;
    if (rden_cnt - rbase != WORDS || rden_empty_cnt != vbase) begin
      n_bad++;
      $display("FAIL stall_rden_total got %0d/%0d want 4/0", rden_cnt - rbase,
               rden_empty_cnt - vbase);
    end
    for (int i = 0; i < WORDS; i++) begin
      n_cmp++;
      if (!ok || sent_mem[(base+i) % 256] !== exp_word(w[i])) begin
        n_bad++;
        $display("FAIL stall_word%0d got %h want %h", i,
                 sent_mem[(base+i) % 256], exp_word(w[i]));
      end
    end
  endtask

  task automatic test_kernel_skew;
    int base, held;
    bit ok, done;
    base = sent_cnt;
    slow_kern = 1;
    for (int i = 0; i < WORDS; i++) push($urandom);
    wait_state(4'b0100, 100, ok);
    held = 0;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (kern_out_valid !== '1) begin
        n_cmp++;
        if (state !== 4'b0100) begin
          n_bad++;
          $display("FAIL skew_hold kov=%b got %h want 4", kern_out_valid, state);
        end
        if (kern_out_valid[THREADS-1]) held++;
        @(negedge bus_clk);
      end else begin
        done = 1;
      end
    end
    @(negedge bus_clk);
    n_cmp++;
    if (!ok || held < 3 || state !== 4'b1000) begin
      n_bad++;
      $display("FAIL skew_release held=%0d got %h want >=3/8", held, state);
    end
    slow_kern = 0;
    wait_sent(base, WORDS, 100, ok);
    bc_exp++;
  endtask

  task automatic test_backpressure;
    logic [BUS_W-1:0] w [WORDS];
    int base;
    bit ok;
    for (int i = 0; i < WORDS; i++) w[i] = $urandom;
    base = sent_cnt;
    for (int i = 0; i < WORDS; i++) push(w[i]);
    wait_sent(base, 2, 200, ok);
    send_almost_full = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++;
      if (send_wren !== 1'b0) begin
        n_bad++; $display("FAIL bp_wren cycle %0d got %b want 0", i, send_wren);
      end
      @(negedge bus_clk);
    end
    send_almost_full = 0;
    n_cmp++;
    if (sent_cnt - base != 2) begin
      n_bad++; $display("FAIL bp_count got %0d want 2", sent_cnt - base);
    end
    wait_sent(base, WORDS, 50, ok);
    bc_exp++;
    for (int i = 0; i < WORDS; i++) begin
      n_cmp++;
      if (!ok || sent_mem[(base+i) % 256] !== exp_word(w[i])) begin
        n_bad++;
        $display("FAIL bp_word%0d got %h want %h", i,
                 sent_mem[(base+i) % 256], exp_word(w[i]));
      end
    end
  endtask

  task automatic test_enable_drop;
    logic [BUS_W-1:0] w [WORDS];
    int base;
    bit ok;
    kern_hold = 1;
    for (int i = 0; i < WORDS; i++) push($urandom);
    wait_state(4'b0100, 100, ok);
    @(negedge bus_clk);
    enable = 0;
    @(posedge bus_clk);
    #1;
    n_cmp++;
    if (!ok || state !== 4'b0001 || kern_in_valid !== '0) begin
      n_bad++;
      $display("FAIL drop_idle got %h/%h want 1/00", state, kern_in_valid);
    end
    n_cmp++;
    if (batch_count !== 16'(bc_exp)) begin
      n_bad++; $display("FAIL drop_bc got %0d want %0d", batch_count, bc_exp);
    end
    @(negedge bus_clk);
    kern_hold = 0;
    enable = 1;
    for (int i = 0; i < WORDS; i++) w[i] = $urandom;
    base = sent_cnt;
    for (int i = 0; i < WORDS; i++) push(w[i]);
    wait_sent(base, WORDS, 200, ok);
    bc_exp++;
    for (int i = 0; i < WORDS; i++) begin
      n_cmp++;
      if (!ok || sent_mem[(base+i) % 256] !== exp_word(w[i])) begin
        n_bad++;
        $display("FAIL drop_word%0d got %h want %h", i,
                 sent_mem[(base+i) % 256], exp_word(w[i]));
      end
    end
  endtask

  task automatic test_rst_send;
    logic [BUS_W-1:0] w [WORDS];
    int base;
    bit ok;
    base = sent_cnt;
    send_almost_full = 1;
    for (int i = 0; i < WORDS; i++) push($urandom);
    wait_state(4'b1000, 100, ok);
    @(negedge bus_clk);
    rst = 1;
    #1;
    bc_exp = 0;
    n_cmp++;
    if (!ok || state !== 4'b0001 || batch_count !== 16'd0) begin
      n_bad++;
      $display("FAIL rst_async got %h/%0d want 1/0", state, batch_count);
    end
    n_cmp++;
    if (kern_in_valid !== '0 || kern_in_data !== '0
        || send_wren !== 1'b0 || recv_rden !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_outputs kv=%h kd=%h wren=%b rden=%b want 0",
               kern_in_valid, kern_in_data, send_wren, recv_rden);
    end
    repeat (2) @(negedge bus_clk);
    rst = 0;
    send_almost_full = 0;
    repeat (3) @(negedge bus_clk);
    n_cmp++;
    if (sent_cnt != base) begin
      n_bad++; $display("FAIL rst_partial got %0d words want 0", sent_cnt - base);
    end
    for (int i = 0; i < WORDS; i++) w[i] = $urandom;
    for (int i = 0; i < WORDS; i++) push(w[i]);
    wait_sent(base, WORDS, 200, ok);
    bc_exp++;
    for (int i = 0; i < WORDS; i++) begin
      n_cmp++;
      if (!ok || sent_mem[(base+i) % 256] !== exp_word(w[i])) begin
        n_bad++;
        $display("FAIL rst_word%0d got %h want %h", i,
                 sent_mem[(base+i) % 256], exp_word(w[i]));
      end
    end
    n_cmp++;
    if (batch_count !== 16'(bc_exp)) begin
      n_bad++; $display("FAIL rst_bc got %0d want %0d", batch_count, bc_exp);
    end
  endtask

  task automatic test_random;
    logic [BUS_W-1:0] w [WORDS];
    int base;
    bit ok;
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < WORDS; i++) w[i] = $urandom;
      base = sent_cnt;
      for (int i = 0; i < WORDS; i++) push(w[i]);
      ok = 0;
      for (int c = 0; c < 400 && !ok; c++) begin
        send_almost_full = ($urandom_range(0, 2) == 0);
        force_empty = ($urandom_range(0, 3) == 0);
        @(negedge bus_clk);
        if (sent_cnt - base >= WORDS) ok = 1;
      end
      send_almost_full = 0;
      force_empty = 0;
      bc_exp++;
      n_cmp++;
      if (!ok) begin
        n_bad++; $display("FAIL rand%0d_timeout got %0d words want 4", b,
                          sent_cnt - base);
      end
      for (int i = 0; i < WORDS; i++) begin
        n_cmp++;
        if (sent_mem[(base+i) % 256] !== exp_word(w[i])) begin
          n_bad++;
          $display("FAIL rand%0d_word%0d got %h want %h", b, i,
                   sent_mem[(base+i) % 256], exp_word(w[i]));
        end
      end
      n_cmp++;
      if (batch_count !== 16'(bc_exp)) begin
        n_bad++; $display("FAIL rand%0d_bc got %0d want %0d", b, batch_count, bc_exp);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_empty_stall();
    test_kernel_skew();
    test_backpressure();
    test_enable_drop();
    test_rst_send();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/warp_controller.md
WARP_CONTROLLER -- requirements
Module: warp_controller

Interface
REQ-001 SHALL have parameter BUS_W, default 32: host stream word width in bits.
REQ-002 SHALL have parameter ELEM_W, default 16: per-thread element width; BUS_W SHALL be an integer multiple of ELEM_W.
REQ-003 SHALL have parameter THREADS, default 512: kernel instance count; THREADS SHALL be a multiple of LANES = BUS_W/ELEM_W.
REQ-004 SHALL have one clock and an asynchronous, active-high reset: bus_clk and rst.
REQ-005 Ports, in order:
- bus_clk  in  1  clock
- rst  in  1  async active-high reset
- enable  in  1  host write and read files open, not quiesced
- recv_rden  out  1  read strobe to inbound FIFO
- recv_empty  in  1  inbound FIFO empty
- recv_data  in  BUS_W  inbound word, valid one cycle after rden
- recv_valid  in  1  recv_data valid
- send_wren  out  1  write strobe to outbound FIFO
- send_data  out  BUS_W  outbound word
- send_almost_full  in  1  outbound FIFO almost full
- kern_in_data  out  THREADS*ELEM_W  per-thread operands, thread i at bits [i*ELEM_W +: ELEM_W]
- kern_in_valid  out  THREADS  per-thread operand valid
- kern_out_data  in  THREADS*ELEM_W  per-thread results, same packing
- kern_out_valid  in  THREADS  per-thread result valid
- state  out  4  one-hot FSM state, for LEDs
- batch_count  out  16  completed batches, wraps at 65535 -> 0

Function
REQ-006 SHALL implement the one-hot FSM: IDLE=0001, RECV=0010, EXEC=0100, SEND=1000.
REQ-007 IDLE->RECV SHALL occur when enable is high; otherwise IDLE is held.
REQ-008 In any state, enable low SHALL force IDLE on the next edge, clear all counters, and deassert all kern_in_valid bits; batch_count SHALL be kept.
REQ-009 WORDS = THREADS/LANES. In RECV, recv_rden SHALL be high only when recv_empty is low and req_cnt < WORDS; req_cnt increments on each rden.
REQ-010 On recv_valid in RECV, lane k (bits [k*ELEM_W +: ELEM_W]) of the word SHALL be stored to thread wr_cnt*LANES+k, and those LANES kern_in_valid bits set; wr_cnt then increments.
REQ-011 RECV->EXEC SHALL occur on the edge at which the WORDS-th recv_valid is accepted; no more than WORDS reads SHALL be issued per batch.
REQ-012 kern_in_data and kern_in_valid SHALL hold stable from storage until the return to IDLE.
REQ-013 EXEC->SEND SHALL occur when all THREADS bits of kern_out_valid are high (AND-reduction), not on any single bit.
REQ-014 In SEND, send_wren = !send_almost_full; send_data lane k SHALL be result of thread rd_cnt*LANES+k; rd_cnt increments on each send_wren.
REQ-015 SEND->IDLE SHALL occur on the edge of the WORDS-th write; batch_count SHALL increment on that edge.
REQ-016 send_almost_full high SHALL stall send with no word skipped or duplicated.
REQ-017 recv_rden and send_wren SHALL be low outside RECV and SEND respectively.

Reset
REQ-018 On rst: state=IDLE, req_cnt=wr_cnt=rd_cnt=0, kern_in_valid=0, kern_in_data=0, batch_count=0, recv_rden=0, send_wren=0.
REQ-019 rst deasserting mid-batch SHALL restart from IDLE; no partial data is emitted.

Structure
REQ-020 A shared package SHALL hold the state encoding constants and the LANES/WORDS derivations.
REQ-021 Counter widths SHALL be $clog2(WORDS+1).
REQ-022 One sub-module, warp_lane_unpack (word-to-thread demux plus valid set), SHALL be natural; the kernel array stays outside this block.

Verification (THREADS=8, ELEM_W=16, BUS_W=32, WORDS=4)
REQ-023 Push words 0x00020001, 0x00040003, 0x00060005, 0x00080007; kernels return input+1 one cycle after valid. Required: send_data 0x00030002, 0x00050004, 0x00070006, 0x00090008; batch_count=1; state back to 0001.
REQ-024 Hold recv_empty high for 5 cycles mid-batch. Required: no rden while empty, exactly 4 rden total, correct thread placement.
REQ-025 Raise kern_out_valid[7] first and the others 3 cycles later. Required: stay in EXEC until all 8 bits are high.
REQ-026 Assert send_almost_full for 4 cycles after the second send word. Required: send_wren low during the stall, the remaining two words intact and in order.
REQ-027 Drop enable during EXEC. Required: IDLE next cycle, kern_in_valid=0, batch_count unchanged, next batch correct.
REQ-028 Assert rst during SEND. Required: all REQ-018 values immediately (asynchronously), batch_count=0.
